// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Two-stage RV32I encoder that range-checks a decoded immediate and
//            packs it with register/funct fields into an instruction word.
// Revision : 1.0 - initial release
// ============================================================================

module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_imm_type,
  input  logic [31:0]          in_imm,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  input  logic                 clear_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0]  c_type_i    = 3'd0;
  localparam logic [2:0]  c_type_istar = 3'd1;
  localparam logic [2:0]  c_type_s    = 3'd2;
  localparam logic [2:0]  c_type_b    = 3'd3;
  localparam logic [2:0]  c_type_u    = 3'd4;
  localparam logic [2:0]  c_type_j    = 3'd5;
  localparam logic [2:0]  c_type_r    = 3'd6;
  localparam logic [31:0] c_nop       = 32'h0000_0013;
  localparam logic [ERR_CNT_W-1:0] c_err_max = '1;
  localparam logic [ERR_CNT_W-1:0] c_err_one = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic                 r_s1_valid;
  logic [31:0]          r_s1_inst;
  logic                 r_s1_err;
  logic                 r_s2_valid;
  logic [31:0]          r_s2_inst;
  logic                 r_s2_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_s1_adv;
  logic                 w_s2_adv;
  logic                 w_out_fire;
  logic                 w_sext12_ok;
  logic                 w_sext13_ok;
  logic                 w_sext21_ok;
  logic [31:0]          w_inst;
  logic                 w_err;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && out_ready;

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;
  assign err_count = r_err_count;

  // An immediate fits an N-bit signed field when every bit above N-2 is a copy of the sign.
  assign w_sext12_ok = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign w_sext13_ok = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign w_sext21_ok = (&in_imm[31:20]) || (~|in_imm[31:20]);

  always_comb begin
    w_inst = c_nop;
    w_err  = 1'b1;
    case (in_imm_type)
      c_type_i: begin
        w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = !w_sext12_ok;
      end
      c_type_istar: begin
        w_inst = {in_funct7, in_rs2, in_imm[4:0], in_funct3, in_rd, in_opcode};
        w_err  = |in_imm[31:5];
      end
      c_type_s: begin
        w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err  = !w_sext12_ok;
      end
      c_type_b: begin
        w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_opcode};
        w_err  = !w_sext13_ok || in_imm[0];
      end
      c_type_u: begin
        w_inst = {in_imm[31:12], in_rd, in_opcode};
        w_err  = |in_imm[11:0];
      end
      c_type_j: begin
        w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_err  = !w_sext21_ok || in_imm[0];
      end
      c_type_r: begin
        w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = 1'b0;
      end
      default: begin
        w_inst = c_nop;
        w_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_inst  <= '0;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_inst <= w_inst;
          r_s1_err  <= w_err;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_inst <= r_s1_inst;
          r_s2_err  <= r_s1_err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (clear_err) begin
      r_err_count <= '0;
    end else if (w_out_fire && r_s2_err && (r_err_count != c_err_max)) begin
      r_err_count <= r_err_count + c_err_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Directed and random stimulus for imm_encoder against a queue model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_imm_encoder;

  localparam int ERR_MAX = 255;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_imm_type;
  logic [31:0] in_imm;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        clear_err;
  logic [7:0]  err_count;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_type(in_imm_type), .in_imm(in_imm), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .clear_err(clear_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          age;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   m_errcnt  = 0;
  int   delivered = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: range checks as signed intervals, fields by shift/mask.
  function automatic void model_encode(
    input int unsigned t, imm, op, rd, rs1, rs2, f3, f7,
    output logic [31:0] inst, output logic err);
    int s;
    int unsigned w;
    s = $signed(imm);
    w = 32'h13;
    err = 1'b1;
    case (t)
      0: begin
        err = !(s >= -2048 && s <= 2047);
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      1: begin
        err = (imm > 31);
        w = (f7 << 25) | (rs2 << 20) | ((imm & 31) << 15) | (f3 << 12) | (rd << 7) | op;
      end
      2: begin
        err = !(s >= -2048 && s <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 31) << 7) | op;
      end
      3: begin
        err = !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
          | (((imm >> 11) & 1) << 7) | op;
      end
      4: begin
        err = (imm % 4096 != 0);
        w = ((imm / 4096) * 4096) | (rd << 7) | op;
      end
      5: begin
        err = !(s >= -1048576 && s <= 1048575) || (imm % 2 != 0);
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      end
      6: begin
        err = 1'b0;
        w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      default: begin
        err = 1'b1;
        w = 32'h13;
      end
    endcase
    inst = w;
  endfunction

  // One clock: check outputs against the model, then apply the edge to the model.
  task automatic tick();
    bit          m_rdy, m_ov, in_fire, out_fire;
    logic [31:0] e_inst;
    logic        e_err;
    exp_t        e;
    #1;
    m_rdy = (q.size() < 2) || out_ready;
    m_ov  = (q.size() > 0) && (q[0].age >= 1);
    check("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("err_count", {24'b0, err_count}, m_errcnt);
    if (m_ov) begin
      check("out_inst", out_inst, q[0].inst);
      check("out_err", {31'b0, out_err}, {31'b0, q[0].err});
    end
    in_fire  = reset_n && in_valid && m_rdy;
    out_fire = reset_n && m_ov && out_ready;
    e_inst = '0;
    e_err  = 1'b0;
    if (in_fire)
      model_encode(in_imm_type, in_imm, in_opcode, in_rd, in_rs1, in_rs2,
                   in_funct3, in_funct7, e_inst, e_err);
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_errcnt = 0;
    end else begin
      if (clear_err) m_errcnt = 0;
      else if (out_fire && q[0].err && m_errcnt < ERR_MAX) m_errcnt = m_errcnt + 1;
      if (out_fire) begin
        void'(q.pop_front());
        delivered++;
      end
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (in_fire) begin
        e.inst = e_inst;
        e.err  = e_err;
        e.age  = 0;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7);
    in_imm_type = t; in_imm = imm; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7;
    in_valid = 1'b1;
  endtask

  task automatic send_one(input string tag, input logic [2:0] t, input logic [31:0] imm,
                          input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] exp_inst, input logic exp_err);
    out_ready = 1'b1;
    drive(t, imm, op, rd, rs1, rs2, f3, 7'd0);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    tick();
    check({tag, "_lat2"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    tick();
  endtask

  function automatic logic [31:0] rand_imm();
    int unsigned v;
    case ($urandom_range(0, 4))
      0: v = $urandom();
      1: v = $urandom_range(0, 8191) - 4096;
      2: v = $urandom() & 32'hFFFF_F000;
      3: v = ($urandom_range(0, 4194303) - 2097152) & 32'hFFFF_FFFE;
      default: v = $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  initial begin
    int d0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    in_imm_type = '0; in_imm = '0; in_opcode = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    send_one("i_neg1", 3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFF1_0093, 1'b0);
    send_one("s_8",    3'd2, 32'd8,        7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 32'h0053_2423, 1'b0);
    send_one("b_m4",   3'd3, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE00_0EE3, 1'b0);
    send_one("j_800",  3'd5, 32'h800,      7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_00EF, 1'b0);
    send_one("u_lui",  3'd4, 32'h1234_5000, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h1234_51B7, 1'b0);
    check("errcnt_0", {24'b0, err_count}, 32'd0);

    send_one("i_800", 3'd0, 32'h800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h8001_0093, 1'b1);
    check("errcnt_1", {24'b0, err_count}, 32'd1);
    send_one("b_5", 3'd3, 32'd5, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0263, 1'b1);
    send_one("u_1", 3'd4, 32'd1, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0000_01B7, 1'b1);
    send_one("rsv", 3'd7, 32'hDEAD_BEEF, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 32'h0000_0013, 1'b1);
    check("errcnt_4", {24'b0, err_count}, 32'd4);

    // Saturation: 260 more errored words on top of the 4 already counted.
    out_ready = 1'b1;
    drive(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    repeat (260) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("errcnt_sat", {24'b0, err_count}, 32'd255);

    drive(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    tick();
    in_valid = 1'b0;
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_prio", {24'b0, err_count}, 32'd0);

    // Backpressure: four distinct R-type words against a stalled consumer.
    out_ready = 1'b0;
    drive(3'd6, 32'd0, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    tick();
    drive(3'd6, 32'd0, 7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
    tick();
    drive(3'd6, 32'd0, 7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    check("bp_hold", out_inst, 32'h0000_00B3);
    out_ready = 1'b1;
    d0 = delivered;
    tick();
    drive(3'd6, 32'd0, 7'h33, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_count", delivered - d0, 32'd4);
    check("bp_empty", q.size(), 32'd0);

    // Reset with two errored words still in flight.
    drive(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    repeat (3) tick();
    in_valid = 1'b0;
    check("pre_rst_errcnt", {24'b0, err_count}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_errcnt", {24'b0, err_count}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    repeat (4) tick();

    for (int n = 0; n < 400; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      clear_err   = ($urandom_range(0, 29) == 0);
      in_imm_type = 3'($urandom_range(0, 7));
      in_imm      = rand_imm();
      in_opcode   = 7'($urandom());
      in_rd       = 5'($urandom());
      in_rs1      = 5'($urandom());
      in_rs2      = 5'($urandom());
      in_funct3   = 3'($urandom());
      in_funct7   = 7'($urandom());
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_err = 1'b0;
    repeat (6) tick();
    check("final_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Pipelined RV32I instruction encoder, the inverse of the stage-1 immediate generator.
- Takes decoded fields (opcode, registers, funct fields) plus a full 32-bit immediate and an immediate type, checks that the immediate is representable, and packs everything into a 32-bit instruction word.
- Feeds the IMEM preload/test-program path and the self-check scoreboard; valid/ready on both sides.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_imm_type  in  3  0=I, 1=I* (CSR zimm), 2=S, 3=B, 4=U, 5=J, 6=R (no imm), 7=reserved.
- in_imm  in  32  immediate in decoded (ImmGen-output) form.
- in_opcode  in  7  inst[6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  inst[14:12].
- in_funct7  in  7  inst[31:25]; for I*, {in_funct7,in_rs2} is the CSR address.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_err  out  1  immediate not representable / reserved type; qualified by out_valid.
- clear_err  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_W  saturating count of errored words delivered.

Behaviour:
- Reset (reset_n=0 at edge): s1_valid=s2_valid=0, out_valid=0, out_inst=0, out_err=0, err_count=0. Pipeline contents discarded, including mid-stream. in_ready is combinational and equals 1 whenever the pipeline is empty, including during reset.
- Two register stages:
  - S1 captures the fields, computes the range check and packs the word.
  - S2 is the output register.
  - Latency is 2 cycles from the accepting edge to out_valid with no backpressure.
  - Throughput is 1 word/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - A transfer occurs on the edge where valid && ready. Held stages keep their data stable.
  - out_inst and out_err are stable while out_valid && !out_ready.
  - Strict FIFO order; no drop or duplication. in_ready may depend combinationally on out_ready.
- Packing (bit ranges high to low):
  - I: {imm[11:0], rs1, f3, rd, op}
  - I*: {funct7, rs2, imm[4:0], f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - R: {funct7, rs2, rs1, f3, rd, op}
  - Type 7: out_inst = 32'h00000013 (NOP).
- Range check (err=1 if violated):
  - I, S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - I*: imm[31:5]=0.
  - R: never errors.
  - Type 7: always errors.
  - On error, the word is still packed from truncated fields (except type 7).
- err_count:
  - Increments by 1 on each out_valid && out_ready && out_err edge.
  - Saturates at 2^ERR_CNT_W-1.
  - clear_err sets it to 0 and takes priority over a simultaneous increment.

Test Plan:
- I-type, op=0x13, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF, out_ready=1 -> out_inst=0xFFF10093, out_err=0, out_valid exactly 2 cycles after accept.
- S-type, op=0x23, f3=2, rs1=6, rs2=5, imm=8 -> 0x00532423. B-type, op=0x63, rs1=rs2=0, f3=0, imm=0xFFFFFFFC -> 0xFE000EE3.
- J-type, op=0x6F, rd=1, imm=0x800 -> 0x001000EF. U-type, op=0x37, rd=3, imm=0x12345000 -> 0x123451B7.
- Errors: I imm=0x800 -> err=1, err_count 0->1. B imm=5 -> err=1. U imm=0x1 -> err=1. Type 7 -> out_inst=0x00000013, err=1. 260 errors -> err_count=255. clear_err together with an errored transfer -> 0.
- Backpressure: out_ready=0, in_valid=1 with 4 distinct words:
  - in_ready drops after 2 accepts.
  - out_inst is held stable.
  - Raising out_ready delivers all 4 words in order, one per cycle, with no loss.
- Reset mid-stream: reset_n=0 for 1 edge with 2 words in flight -> out_valid=0, err_count=0, in_ready=1 next cycle. Flushed words are never emitted.
